idli_mem_arb_m: RTL and testbench

IDLI_MEM_ARB_M -- requirements
Module: idli_mem_arb_m

---
 rtl/idli_mem_arb_m.sv | 113 +++++++++++
 tb/tb_idli_mem_arb_m.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: arbitrates instruction fetch, branch redirects and load/store
// traffic onto a nibble-wide SQI memory interface, one state per 4-GCK period.
module idli_mem_arb_m (
    input  logic        i_arb_gck,
    input  logic        i_arb_rst_n,
    input  logic [1:0]  i_arb_ctr,
    input  logic        i_arb_br_vld,
    input  logic [15:0] i_arb_br_addr,
    input  logic        i_arb_ls_vld,
    input  logic        i_arb_ls_wr,
    input  logic [15:0] i_arb_ls_addr,
    input  logic [15:0] i_arb_ls_data,
    input  logic        i_arb_dec_stall,
    input  logic [15:0] i_arb_instr,
    input  logic        i_arb_instr_vld,
    output logic        o_arb_redirect,
    output logic        o_arb_wr_en,
    output logic        o_arb_stall,
    output logic [3:0]  o_arb_slice,
    output logic        o_arb_ls_ack,
    output logic        o_arb_ld_vld,
    output logic [15:0] o_arb_ld_data,
    output logic [15:0] o_arb_pc
);
    typedef logic [15:0] data_t;
    typedef logic [3:0]  slice_t;
    typedef logic [1:0]  ctr_t;
    typedef enum logic [2:0] {FETCH, REDIR, RESET, INSTR, ADDR_HI, ADDR_LO, DUMMY, LS_DATA} state_t;

    state_t state_q, state_d;
    data_t  pc_q, pc_d;
    data_t  tgt_q, tgt_d;
    data_t  data_q, data_d;
    logic   ls_q, ls_d;
    logic   wr_q, wr_d;
    ctr_t   ctr;
    logic   end_w;

    assign ctr   = i_arb_ctr;
    assign end_w = &ctr;

    // tgt holds the address being streamed in REDIR so later branches only move pc
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        data_d  = data_q;
        ls_d    = ls_q;
        wr_d    = wr_q;
        if (state_q == FETCH) begin
            if (i_arb_instr_vld && !i_arb_dec_stall)
                pc_d = pc_q + 16'd1;
        end else if (i_arb_br_vld) begin
            pc_d = i_arb_br_addr;
        end
        if (end_w) begin
            case (state_q)
                FETCH: begin
                    if (i_arb_ls_vld || i_arb_br_vld) begin
                        state_d = REDIR;
                        tgt_d   = i_arb_ls_vld ? i_arb_ls_addr : i_arb_br_addr;
                        ls_d    = i_arb_ls_vld;
                        wr_d    = i_arb_ls_vld && i_arb_ls_wr;
                        data_d  = i_arb_ls_vld ? i_arb_ls_data : data_q;
                        pc_d    = i_arb_br_vld ? i_arb_br_addr : pc_d;
                    end
                end
                REDIR:   state_d = RESET;
                RESET:   state_d = INSTR;
                INSTR:   state_d = ADDR_HI;
                ADDR_HI: state_d = ADDR_LO;
                ADDR_LO: state_d = wr_q ? LS_DATA : DUMMY;
                DUMMY:   state_d = ls_q ? LS_DATA : FETCH;
                LS_DATA: begin
                    state_d = REDIR;
                    tgt_d   = i_arb_br_vld ? i_arb_br_addr : pc_q;
                    ls_d    = 1'b0;
                    wr_d    = 1'b0;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
        if (!i_arb_rst_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            tgt_q   <= '0;
            data_q  <= '0;
            ls_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            data_q  <= data_d;
            ls_q    <= ls_d;
            wr_q    <= wr_d;
        end
    end

    // inputs feeding stall/ack are gated so every output reads 0 while in reset
    assign o_arb_redirect = state_q == REDIR;
    assign o_arb_wr_en    = wr_q && (state_q inside {INSTR, ADDR_HI, ADDR_LO, LS_DATA});
    assign o_arb_stall    = i_arb_rst_n && state_q == FETCH && i_arb_dec_stall;
    assign o_arb_slice    = state_q == REDIR ? slice_t'(tgt_q[{ctr, 2'b00} +: 4]) :
                            (state_q == ADDR_LO && wr_q) ? slice_t'(data_q[{ctr, 2'b00} +: 4]) : '0;
    assign o_arb_ls_ack   = i_arb_rst_n && state_q == FETCH && end_w && i_arb_ls_vld;
    assign o_arb_ld_vld   = state_q == LS_DATA && ls_q && !wr_q && end_w;
    assign o_arb_ld_data  = o_arb_ld_vld ? i_arb_instr : '0;
    assign o_arb_pc       = pc_q;
endmodule

// File: tb/tb_idli_mem_arb_m.sv
// tb_idli_mem_arb_m: table-driven per-period vectors for idli_mem_arb_m plus
// hand-written reset sequences.
module tb_idli_mem_arb_m;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctr;
    logic        br_vld, ls_vld, ls_wr, dec_stall, instr_vld;
    logic [15:0] br_addr, ls_addr, ls_data, instr;
    logic        redirect, wr_en, stall, ls_ack, ld_vld;
    logic [3:0]  slice;
    logic [15:0] ld_data, pc;

    always #5 clk = ~clk;

    idli_mem_arb_m dut (
        .i_arb_gck(clk), .i_arb_rst_n(rst_n), .i_arb_ctr(ctr),
        .i_arb_br_vld(br_vld), .i_arb_br_addr(br_addr),
        .i_arb_ls_vld(ls_vld), .i_arb_ls_wr(ls_wr), .i_arb_ls_addr(ls_addr), .i_arb_ls_data(ls_data),
        .i_arb_dec_stall(dec_stall), .i_arb_instr(instr), .i_arb_instr_vld(instr_vld),
        .o_arb_redirect(redirect), .o_arb_wr_en(wr_en), .o_arb_stall(stall), .o_arb_slice(slice),
        .o_arb_ls_ack(ls_ack), .o_arb_ld_vld(ld_vld), .o_arb_ld_data(ld_data), .o_arb_pc(pc)
    );

    // input flags {br, ls, wr, stall}; expected flags {redirect, wr_en, ack@3, ld_vld@3, stall}
    localparam logic [3:0] BR = 4'b1000, LS = 4'b0100, WR = 4'b0010, ST = 4'b0001, NI = 4'b0000;
    localparam logic [4:0] RD = 5'b10000, WE = 5'b01000, AK = 5'b00100, LD = 5'b00010, SL = 5'b00001, NE = 5'b00000;
    localparam logic [15:0] Z = 16'h0000;

    typedef struct {
        logic [15:0] e_pc;
        logic [3:0]  fin;
        logic [3:0]  ivld;
        logic [15:0] baddr;
        logic [15:0] laddr;
        logic [15:0] ldata;
        logic [4:0]  fex;
        logic [15:0] eslice;
    } vec_t;

    vec_t q[$];
    vec_t q2[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int idx, input int c, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d ctr %0d: got %h want %h", nm, idx, c, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] p, input logic [3:0] fi, input logic [3:0] iv, input logic [15:0] ba,
                       input logic [15:0] la, input logic [15:0] ld, input logic [4:0] fx, input logic [15:0] es);
        q.push_back('{p, fi, iv, ba, la, ld, fx, es});
    endtask

    task automatic idle(input int n, input logic [15:0] p);
        repeat (n) add(p, NI, 4'h0, Z, Z, Z, NE, Z);
    endtask

    // REDIR to a read target followed by RESET, INSTR, ADDR_HI, ADDR_LO, DUMMY
    task automatic redir_rd(input logic [15:0] tgt, input logic [15:0] p);
        add(p, NI, 4'h0, Z, Z, Z, RD, tgt);
        idle(5, p);
    endtask

    task automatic drive_idle();
        br_vld = 0; ls_vld = 0; ls_wr = 0; dec_stall = 0; instr_vld = 0;
        br_addr = Z; ls_addr = Z; ls_data = Z; instr = Z;
    endtask

    task automatic chk_zero(input int idx);
        chk("rst_redirect", idx, int'(ctr), {15'b0, redirect}, Z);
        chk("rst_wr_en", idx, int'(ctr), {15'b0, wr_en}, Z);
        chk("rst_stall", idx, int'(ctr), {15'b0, stall}, Z);
        chk("rst_slice", idx, int'(ctr), {12'b0, slice}, Z);
        chk("rst_ack", idx, int'(ctr), {15'b0, ls_ack}, Z);
        chk("rst_ld_vld", idx, int'(ctr), {15'b0, ld_vld}, Z);
        chk("rst_ld_data", idx, int'(ctr), ld_data, Z);
        chk("rst_pc", idx, int'(ctr), pc, Z);
    endtask

    task automatic run(input vec_t v, input int idx);
        logic last;
        for (int c = 0; c < 4; c++) begin
            last = (c == 3);
            ctr = 2'(c);
            br_vld = v.fin[3]; ls_vld = v.fin[2]; ls_wr = v.fin[1]; dec_stall = v.fin[0];
            br_addr = v.baddr; ls_addr = v.laddr; ls_data = v.ldata;
            instr_vld = v.ivld[c];
            instr = 16'hA000 ^ 16'(idx * 37 + c);
            #1;
            if (c == 0) chk("pc", idx, c, pc, v.e_pc);
            chk("redirect", idx, c, {15'b0, redirect}, {15'b0, v.fex[4]});
            chk("wr_en", idx, c, {15'b0, wr_en}, {15'b0, v.fex[3]});
            chk("ack", idx, c, {15'b0, ls_ack}, {15'b0, v.fex[2] && last});
            chk("ld_vld", idx, c, {15'b0, ld_vld}, {15'b0, v.fex[1] && last});
            chk("ld_data", idx, c, ld_data, (v.fex[1] && last) ? instr : Z);
            chk("stall", idx, c, {15'b0, stall}, {15'b0, v.fex[0]});
            chk("slice", idx, c, {12'b0, slice}, {12'b0, v.eslice[4*c +: 4]});
            @(posedge clk); #2;
        end
    endtask

    initial begin
        rst_n = 0; ctr = 2'd3;
        br_vld = 1; ls_vld = 1; ls_wr = 1; dec_stall = 1; instr_vld = 1;
        br_addr = 16'hFFFF; ls_addr = 16'hFFFF; ls_data = 16'hFFFF; instr = 16'hFFFF;
        #3 chk_zero(-1);
        repeat (2) @(posedge clk);
        #2 chk_zero(-2);
        drive_idle(); ctr = 2'd0; rst_n = 1;

        add(16'h0000, NI, 4'b0111, Z, Z, Z, NE, Z);
        add(16'h0003, ST, 4'b1111, Z, Z, Z, SL, Z);
        add(16'h0003, BR, 4'h0, 16'h1234, Z, Z, NE, Z);
        redir_rd(16'h1234, 16'h1234);
        add(16'h1234, BR, 4'h0, 16'h0010, Z, Z, NE, Z);
        redir_rd(16'h0010, 16'h0010);
        add(16'h0010, LS, 4'h0, Z, 16'h00A0, Z, AK, Z);
        redir_rd(16'h00A0, 16'h0010);
        add(16'h0010, NI, 4'h0, Z, Z, Z, LD, Z);
        redir_rd(16'h0010, 16'h0010);
        add(16'h0010, LS | WR, 4'h0, Z, 16'h0040, 16'hBEEF, AK, Z);
        add(16'h0010, NI, 4'h0, Z, Z, Z, RD, 16'h0040);
        add(16'h0010, NI, 4'h0, Z, Z, Z, NE, Z);
        add(16'h0010, NI, 4'h0, Z, Z, Z, WE, Z);
        add(16'h0010, NI, 4'h0, Z, Z, Z, WE, Z);
        add(16'h0010, NI, 4'h0, Z, Z, Z, WE, 16'hBEEF);
        add(16'h0010, NI, 4'h0, Z, Z, Z, WE, Z);
        redir_rd(16'h0010, 16'h0010);
        add(16'h0010, LS | BR, 4'h0, 16'h0200, 16'h0300, Z, AK, Z);
        add(16'h0200, NI, 4'h0, Z, Z, Z, RD, 16'h0300);
        add(16'h0200, BR, 4'h0, 16'h0500, Z, Z, NE, Z);
        add(16'h0500, BR, 4'h0, 16'h0200, Z, Z, NE, Z);
        idle(3, 16'h0200);
        add(16'h0200, NI, 4'h0, Z, Z, Z, LD, Z);
        redir_rd(16'h0200, 16'h0200);
        add(16'h0200, BR, 4'h0, 16'hFFFF, Z, Z, NE, Z);
        add(16'hFFFF, NI, 4'h0, Z, Z, Z, RD, 16'hFFFF);
        add(16'hFFFF, LS | ST, 4'h0, Z, 16'h0123, Z, NE, Z);
        add(16'hFFFF, LS, 4'h0, Z, 16'h0123, Z, NE, Z);
        idle(3, 16'hFFFF);
        add(16'hFFFF, NI, 4'b0001, Z, Z, Z, NE, Z);
        add(16'h0000, NI, 4'h0, Z, Z, Z, NE, Z);
        add(16'h0000, LS | WR, 4'h0, Z, 16'h0040, 16'h1234, AK, Z);
        add(16'h0000, NI, 4'h0, Z, Z, Z, RD, 16'h0040);
        add(16'h0000, NI, 4'h0, Z, Z, Z, NE, Z);
        add(16'h0000, NI, 4'h0, Z, Z, Z, WE, Z);
        foreach (q[i]) run(q[i], i);

        // store in ADDR_HI: wr_en must drop the instant reset asserts
        drive_idle(); ctr = 2'd0;
        #1 chk("addr_hi_wr_en", 900, 0, {15'b0, wr_en}, 16'h0001);
        @(posedge clk); #2;
        ctr = 2'd1;
        #1 chk("addr_hi_wr_en", 900, 1, {15'b0, wr_en}, 16'h0001);
        rst_n = 0; ctr = 2'd3; ls_vld = 1; br_vld = 1; br_addr = 16'h7777; dec_stall = 1;
        #1 chk_zero(901);
        @(posedge clk); #2;
        chk_zero(902);
        drive_idle(); ctr = 2'd0; rst_n = 1;

        q = {};
        add(16'h0000, NI, 4'b0001, Z, Z, Z, NE, Z);
        add(16'h0001, NI, 4'h0, Z, Z, Z, NE, Z);
        foreach (q[i]) run(q[i], 1000 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
